// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
// Stage registers use NOP_INSTR when they load a bubble.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    MC_WAIT  = 2'd2
  } ctrl_state_t;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic ifid_flush;
    logic idex_en;
    logic idex_flush;
    logic exmem_en;
    logic exmem_flush;
    logic memwb_en;
  } stage_ctrl_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // The packed layout of stage_ctrl_t determines each bit position below.
  localparam stage_ctrl_t CTRL_IDLE    = 8'b0000_0000;
  localparam stage_ctrl_t CTRL_FLOW    = 8'b1101_0101;
  localparam stage_ctrl_t CTRL_FREEZE  = 8'b0000_0000;
  localparam stage_ctrl_t CTRL_MC_HOLD = 8'b0000_0111;
  localparam stage_ctrl_t CTRL_BRANCH  = 8'b1111_1101;
  localparam stage_ctrl_t CTRL_LOADUSE = 8'b0001_1101;

  // Map the unused encoding back onto RUN so the FSM always recovers.
  function automatic ctrl_state_t legalize_state(input ctrl_state_t s);
    case (s)
      RUN, MEM_WAIT, MC_WAIT: legalize_state = s;
      default:                legalize_state = RUN;
    endcase
  endfunction

endpackage

// File: rtl/pipeline_controller_sat_counter.sv
// Saturating up-counter: holds at all-ones once reached.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: resolves load-use, taken
// branch, data-memory wait and multi-cycle EX hazards; keeps perf counters.
module pipeline_controller
  import pipeline_ctrl_pkg::*;
#(
  parameter int REG_SIZE  = 5,
  parameter int CNT_WIDTH = 32,
  parameter int TIMEOUT   = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_SIZE-1:0]  id_rs1,
  input  logic [REG_SIZE-1:0]  id_rs2,
  input  logic                 id_uses_rs1,
  input  logic                 id_uses_rs2,
  input  logic                 ex_memRead,
  input  logic [REG_SIZE-1:0]  ex_rd,
  input  logic                 ex_branch_taken,
  input  logic                 ex_mc_start,
  input  logic                 ex_mc_done,
  input  logic                 mem_req,
  input  logic                 mem_ready,
  output logic                 pc_en,
  output logic                 ifid_en,
  output logic                 idex_en,
  output logic                 exmem_en,
  output logic                 memwb_en,
  output logic                 ifid_flush,
  output logic                 idex_flush,
  output logic                 exmem_flush,
  output logic [1:0]           state_o,
  output logic [CNT_WIDTH-1:0] stall_cnt,
  output logic [CNT_WIDTH-1:0] flush_cnt,
  output logic                 mem_timeout
);

  localparam int WAIT_W = $clog2(TIMEOUT) + 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  ctrl_state_t       state_q;
  ctrl_state_t       state_eff;
  ctrl_state_t       state_d;
  stage_ctrl_t       ctrl;
  logic              memfreeze;
  logic              loaduse;
  logic              mc_pending;
  logic              branch_fire;
  logic [WAIT_W-1:0] wait_cnt;

  assign memfreeze  = mem_req && !mem_ready;
  assign mc_pending = ex_mc_start && !ex_mc_done;
  assign loaduse    = ex_memRead && (ex_rd != '0) &&
                      (((ex_rd == id_rs1) && id_uses_rs1) ||
                       ((ex_rd == id_rs2) && id_uses_rs2));
  assign state_eff  = legalize_state(state_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_eff;
    case (state_eff)
      RUN: begin
        if (memfreeze) begin
          state_d = MEM_WAIT;
        end else if (mc_pending) begin
          state_d = MC_WAIT;
        end
      end
      MEM_WAIT: begin
        if (!memfreeze) begin
          state_d = mc_pending ? MC_WAIT : RUN;
        end
      end
      MC_WAIT: begin
        if (ex_mc_done && !memfreeze) begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    ctrl        = CTRL_FLOW;
    branch_fire = 1'b0;
    if (memfreeze) begin
      ctrl = CTRL_FREEZE;
    end else if ((state_eff == MC_WAIT) && !ex_mc_done) begin
      ctrl = CTRL_MC_HOLD;
    end else if (ex_branch_taken) begin
      ctrl        = CTRL_BRANCH;
      branch_fire = 1'b1;
    end else if (loaduse) begin
      ctrl = CTRL_LOADUSE;
    end
    // Nothing moves and nothing is counted while reset is held.
    if (rst) begin
      ctrl        = CTRL_IDLE;
      branch_fire = 1'b0;
    end
  end

  assign pc_en       = ctrl.pc_en;
  assign ifid_en     = ctrl.ifid_en;
  assign ifid_flush  = ctrl.ifid_flush;
  assign idex_en     = ctrl.idex_en;
  assign idex_flush  = ctrl.idex_flush;
  assign exmem_en    = ctrl.exmem_en;
  assign exmem_flush = ctrl.exmem_flush;
  assign memwb_en    = ctrl.memwb_en;
  assign state_o     = state_q;

  // Timeout flags a stuck access but does not unfreeze the pipeline.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else if ((state_eff == MEM_WAIT) && memfreeze) begin
      if (wait_cnt == WAIT_LAST) begin
        mem_timeout <= 1'b1;
      end else begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end else begin
      wait_cnt <= '0;
    end
  end

  sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (!ctrl.pc_en && !rst),
    .count (stall_cnt)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (branch_fire),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_pipeline_controller.sv
// Directed bench for pipeline_controller with a scoreboard of expected
// stage controls and state, compared mid-cycle.
module tb_pipeline_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_uses_rs1, id_uses_rs2, ex_memRead, ex_branch_taken;
  logic        ex_mc_start, ex_mc_done, mem_req, mem_ready;
  logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic        ifid_flush, idex_flush, exmem_flush;
  logic [1:0]  state_o;
  logic [31:0] stall_cnt, flush_cnt;
  logic        mem_timeout;

  int checks   = 0;
  int failures = 0;

  localparam logic [7:0] E_RST  = 8'b0000_0000;
  localparam logic [7:0] E_DEF  = 8'b1101_0101;
  localparam logic [7:0] E_FRZ  = 8'b0000_0000;
  localparam logic [7:0] E_MCW  = 8'b0000_0111;
  localparam logic [7:0] E_BR   = 8'b1111_1101;
  localparam logic [7:0] E_LU   = 8'b0001_1101;

  typedef struct {
    string      tag;
    logic [7:0] ctrl;
    logic [1:0] st;
  } exp_t;

  exp_t sb[$];

  wire [7:0] ctrl_obs = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
                         exmem_en, exmem_flush, memwb_en};

  always #5 clk = ~clk;

  pipeline_controller #(.REG_SIZE(5), .CNT_WIDTH(32), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_memRead(ex_memRead), .ex_rd(ex_rd),
    .ex_branch_taken(ex_branch_taken),
    .ex_mc_start(ex_mc_start), .ex_mc_done(ex_mc_done),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
    .exmem_en(exmem_en), .memwb_en(memwb_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
    .state_o(state_o), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
    .mem_timeout(mem_timeout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input string tag, input logic [7:0] c, input logic [1:0] s);
    exp_t e;
    e.tag  = tag;
    e.ctrl = c;
    e.st   = s;
    sb.push_back(e);
  endtask

  task automatic pop_cmp();
    exp_t e;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({e.tag, "_ctrl"}, {24'd0, ctrl_obs}, {24'd0, e.ctrl});
      chk({e.tag, "_state"}, {30'd0, state_o}, {30'd0, e.st});
    end
  endtask

  // Called just after a rising edge with inputs already driven.
  task automatic cyc(input string tag, input logic [7:0] c, input logic [1:0] s);
    push_exp(tag, c, s);
    #2;
    pop_cmp();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
    id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; ex_memRead = 1'b0;
    ex_branch_taken = 1'b0; ex_mc_start = 1'b0; ex_mc_done = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    #3;
    push_exp("reset", E_RST, 2'd0);
    pop_cmp();
    chk("reset_stall", stall_cnt, 32'd0);
    chk("reset_flush", flush_cnt, 32'd0);
    chk("reset_tmo", {31'd0, mem_timeout}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    cyc("idle", E_DEF, 2'd0);

    ex_memRead = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
    cyc("loaduse_rs1", E_LU, 2'd0);
    chk("lu_stall", stall_cnt, 32'd1);
    idle_inputs();
    cyc("after_loaduse", E_DEF, 2'd0);
    chk("lu_one_cycle", stall_cnt, 32'd1);

    ex_memRead = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_uses_rs1 = 1'b1;
    cyc("rd_zero", E_DEF, 2'd0);
    chk("rd_zero_stall", stall_cnt, 32'd1);

    ex_memRead = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
    ex_branch_taken = 1'b1;
    cyc("branch_beats_lu", E_BR, 2'd0);
    chk("br_flush", flush_cnt, 32'd1);
    chk("br_stall", stall_cnt, 32'd1);
    idle_inputs();

    ex_memRead = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_uses_rs2 = 1'b0;
    cyc("rs2_unused", E_DEF, 2'd0);
    id_uses_rs2 = 1'b1;
    cyc("loaduse_rs2", E_LU, 2'd0);
    chk("lu2_stall", stall_cnt, 32'd2);
    idle_inputs();

    mem_req = 1'b1; mem_ready = 1'b1;
    cyc("mem_hit", E_DEF, 2'd0);
    mem_ready = 1'b0;
    cyc("mw0", E_FRZ, 2'd0);
    cyc("mw1", E_FRZ, 2'd1);
    cyc("mw2", E_FRZ, 2'd1);
    mem_ready = 1'b1;
    cyc("mw_release", E_DEF, 2'd1);
    idle_inputs();
    cyc("mw_back_run", E_DEF, 2'd0);
    chk("mw_stall", stall_cnt, 32'd5);

    ex_mc_start = 1'b1;
    cyc("mc_start", E_DEF, 2'd0);
    ex_mc_start = 1'b0;
    cyc("mc_wait1", E_MCW, 2'd2);
    mem_req = 1'b1;
    cyc("mc_nested_freeze", E_FRZ, 2'd2);
    mem_req = 1'b0;
    cyc("mc_wait3", E_MCW, 2'd2);
    ex_mc_done = 1'b1;
    cyc("mc_done", E_DEF, 2'd2);
    ex_mc_done = 1'b0;
    cyc("mc_back_run", E_DEF, 2'd0);
    chk("mc_stall", stall_cnt, 32'd8);

    ex_mc_start = 1'b1; ex_mc_done = 1'b1;
    cyc("mc_single", E_DEF, 2'd0);
    idle_inputs();
    cyc("mc_single_next", E_DEF, 2'd0);
    chk("mc_single_stall", stall_cnt, 32'd8);

    mem_req = 1'b1;
    cyc("tmo_0", E_FRZ, 2'd0);
    for (int i = 1; i < 8; i++) cyc("tmo_wait", E_FRZ, 2'd1);
    chk("tmo_not_yet", {31'd0, mem_timeout}, 32'd0);
    cyc("tmo_8", E_FRZ, 2'd1);
    chk("tmo_set", {31'd0, mem_timeout}, 32'd1);
    cyc("tmo_9", E_FRZ, 2'd1);
    mem_ready = 1'b1;
    cyc("tmo_release", E_DEF, 2'd1);
    idle_inputs();
    cyc("tmo_back_run", E_DEF, 2'd0);
    chk("tmo_sticky", {31'd0, mem_timeout}, 32'd1);
    chk("tmo_stall", stall_cnt, 32'd18);
    chk("tmo_flush", flush_cnt, 32'd1);

    ex_mc_start = 1'b1;
    cyc("rst_mc_start", E_DEF, 2'd0);
    ex_mc_start = 1'b0;
    cyc("rst_mc_wait", E_MCW, 2'd2);
    #2;
    rst = 1'b1;
    #1;
    push_exp("mid_reset", E_RST, 2'd0);
    pop_cmp();
    chk("mid_rst_stall", stall_cnt, 32'd0);
    chk("mid_rst_flush", flush_cnt, 32'd0);
    chk("mid_rst_tmo", {31'd0, mem_timeout}, 32'd0);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    cyc("post_reset", E_DEF, 2'd0);
    chk("post_rst_stall", stall_cnt, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipeline_controller.md
Name: pipeline_controller

Overview:
- Central stall/flush sequencer for the 5-stage RISC-V pipeline. It sits beside the forwarding unit.
- Resolves the hazards forwarding cannot cover: load-use, taken branch/jump, data-memory wait states and multi-cycle EX ops.
- Drives the enable and flush of PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Keeps saturating stall/flush performance counters and a sticky memory-timeout flag.

Parameters:
- REG_SIZE, 5, register-index width.
- CNT_WIDTH, 32, performance-counter width.
- TIMEOUT, 1024, MEM_WAIT cycles before mem_timeout sets.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- id_rs1, id_rs2  input  REG_SIZE  source registers of the instruction in ID.
- id_uses_rs1, id_uses_rs2  input  1  ID instruction actually reads rs1/rs2.
- ex_memRead  input  1  instruction in EX is a load.
- ex_rd  input  REG_SIZE  destination of the instruction in EX.
- ex_branch_taken  input  1  branch/jump in EX resolved taken.
- ex_mc_start  input  1  multi-cycle op (mul/div) in EX, first cycle.
- ex_mc_done  input  1  multi-cycle result valid; held high until a cycle with exmem_en=1.
- mem_req  input  1  MEM stage is accessing data memory.
- mem_ready  input  1  data memory completes the access this cycle.
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  output  1  stage-register load enables.
- ifid_flush, idex_flush, exmem_flush  output  1  load a bubble (NOP, regWrite=0) instead of data.
- state_o  output  2  current FSM state, for debug.
- stall_cnt  output  CNT_WIDTH  cycles with pc_en=0.
- flush_cnt  output  CNT_WIDTH  taken-branch flush events.
- mem_timeout  output  1  sticky error.

Behaviour:
- Reset (async, rst=1):
  - state=RUN; stall_cnt=0, flush_cnt=0, wait_cnt=0, mem_timeout=0.
  - While rst=1, all *_en=0 and all *_flush=0.
- Outputs are combinational from state and inputs. Only state, counters and mem_timeout are registered.
- Default (no hazard): all *_en=1, all *_flush=0.
- Signal definitions:
  - memfreeze = mem_req && !mem_ready.
  - loaduse = ex_memRead && ex_rd!=0 && ((ex_rd==id_rs1 && id_uses_rs1) || (ex_rd==id_rs2 && id_uses_rs2)).
- Priority, per cycle, highest first:
  - 1. memfreeze: all five *_en=0, no flushes. The WB re-write is idempotent.
  - 2. MC_WAIT && !ex_mc_done: pc_en=ifid_en=idex_en=0; exmem_flush=1; memwb_en=1, so MEM/WB drain.
  - 3. ex_branch_taken: ifid_flush=1, idex_flush=1, pc_en=1 (PC loads target). This beats loaduse because the ID instruction is discarded.
  - 4. loaduse: pc_en=ifid_en=0, idex_flush=1 (one bubble). The next cycle's ex_memRead comes from the bubble, so the stall lasts exactly one cycle.
- FSM states: RUN=0, MEM_WAIT=1, MC_WAIT=2.
  - RUN: memfreeze -> MEM_WAIT; else ex_mc_start && !ex_mc_done -> MC_WAIT; else RUN.
  - MEM_WAIT: mem_ready=1 -> RUN, with enables released in that same cycle. Exception: if ex_mc_start && !ex_mc_done that cycle -> MC_WAIT.
  - MC_WAIT: ex_mc_done && !memfreeze -> RUN, with exmem_en=1 capturing the result. A memfreeze in MC_WAIT freezes everything and stays in MC_WAIT.
  - Single-cycle MC (ex_mc_start && ex_mc_done in the same cycle): no stall.
- Counters:
  - stall_cnt: +1 each cycle pc_en=0 (rst excluded); saturates at all-ones.
  - flush_cnt: +1 each cycle priority-3 fires; saturates.
  - wait_cnt: +1 each cycle in MEM_WAIT, cleared on leaving MEM_WAIT. When it reaches TIMEOUT-1 with memfreeze still asserted, mem_timeout sets and stays 1 until rst. The pipeline stays frozen.
- Boundaries:
  - ex_rd=0 never causes a loaduse.
  - mem_req && mem_ready in RUN: no stall, no state change.
  - Reset mid-MEM_WAIT or mid-MC_WAIT: returns to RUN immediately and asynchronously.
  - Illegal state encoding 3: treated as RUN, next state RUN.

Decomposition:
- pipeline_ctrl_pkg holds:
  - ctrl_state_t enum {RUN, MEM_WAIT, MC_WAIT}, 2-bit.
  - stage_ctrl_t struct {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush, memwb_en}.
  - Constant NOP encoding 32'h0000_0013 for bubble insertion by the stage registers.
- One sub-module: sat_counter (params WIDTH; ports clk, rst, inc, count), instantiated for stall_cnt and flush_cnt.

Test Plan:
- Load-use: ex_memRead=1, ex_rd=5, id_rs1=5, id_uses_rs1=1 for one cycle -> pc_en=0, ifid_en=0, idex_flush=1 that cycle only; stall_cnt 0->1.
- Branch beats load-use: same as above plus ex_branch_taken=1 -> pc_en=1, ifid_flush=1, idex_flush=1; flush_cnt=1, stall_cnt unchanged.
- Memory wait: mem_req=1 with mem_ready low 3 cycles, then high -> all en=0 for 3 cycles, state 0->1->1->1->0, release on the ready cycle; stall_cnt=3.
- Multi-cycle op: ex_mc_start=1 with done after 4 cycles -> MC_WAIT for 4 cycles, exmem_flush=1, memwb_en=1. Nested memfreeze on cycle 2 -> memwb_en=0 that cycle; release on done.
- Timeout: TIMEOUT=8, mem_ready held 0 for 10 cycles -> mem_timeout=1 after 8th wait cycle, remains 1 after mem_ready; cleared only by rst.
- Async reset mid-MC_WAIT: pulse rst between edges -> state_o=0, counters=0, enables 0 while rst=1, default enables after release.
